// File: rtl/bz_worm_serializer.sv
// Core-to-router serializer: splits {route, code, data} words into {payload, tail} flits and
// keeps a worm open across consecutive same-route words until route change, word limit or idle timeout.
module bz_worm_serializer #(
   parameter int NPCroute  = 10,
   parameter int NPCcode   = 8,
   parameter int NPCdata   = 24,
   parameter int NHold     = 16,
   parameter int NMaxWords = 8
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NPCroute+NPCcode+NPCdata-1:0] PC_in_channel_d,
   input  logic                                PC_in_channel_v,
   output logic                                PC_in_channel_a,
   input  logic                                is_full,
   output logic [NPCroute:0]                   data_out,
   output logic                                wrreq
);

   localparam int W   = NPCroute;
   localparam int NP  = NPCcode + NPCdata;
   localparam int K   = (NP + W - 1) / W;
   localparam int PW  = K * W;
   localparam int PAD = PW - NP;
   localparam int IW  = (K > 1) ? $clog2(K) : 1;
   localparam int TW  = (NHold > 0) ? $clog2(NHold + 1) : 1;
   localparam int CW  = $clog2(NMaxWords + 1);

   localparam bit            MULTI_FLIT   = (K > 1);
   localparam bit            CAN_CONTINUE = (NHold > 0);
   localparam logic [IW-1:0] IDX_PENULT   = IW'((K > 1) ? K - 2 : 0);
   localparam logic [TW-1:0] HOLD_MAX     = TW'(NHold);
   localparam logic [CW-1:0] WORDS_MAX    = CW'(NMaxWords);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HDR  = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   logic [1:0]    state;
   logic [NP-1:0] payload;
   logic [W-1:0]  last_route;
   logic [IW-1:0] idx;
   logic [W-1:0]  held;
   logic [TW-1:0] timer;
   logic [CW-1:0] words;

   logic [W-1:0]  in_route;
   logic [NP-1:0] in_payload;
   logic [PW-1:0] padded;
   logic [W-1:0]  cur_flit;
   logic          same_route;
   logic          at_limit;
   logic          timed_out;
   logic          continue_worm;
   logic          close_worm;

   assign in_route   = PC_in_channel_d[NP +: W];
   assign in_payload = PC_in_channel_d[NP-1:0];

   // Payload left-aligned in K*W bits so the last flit is zero-padded in its LSBs.
   assign padded   = PW'(payload) << PAD;
   assign cur_flit = padded[PW - 1 - int'(idx) * W -: W];

   assign same_route = (in_route == last_route);
   assign at_limit   = (words == WORDS_MAX);
   assign timed_out  = (timer == HOLD_MAX);

   // With NHold==0 each word closes its own worm, so continuation is disabled outright.
   assign continue_worm = (state == S_HOLD) && CAN_CONTINUE && PC_in_channel_v
                          && same_route && !at_limit && !is_full;
   assign close_worm    = (state == S_HOLD) && !continue_worm
                          && ((PC_in_channel_v && (!same_route || at_limit)) || timed_out);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      wrreq           = 1'b0;
      data_out        = '0;
      PC_in_channel_a = 1'b0;
      if (!reset) begin
         case (state)
            S_IDLE: PC_in_channel_a = PC_in_channel_v;
            S_HDR: begin
               if (!is_full) begin
                  wrreq    = 1'b1;
                  data_out = {last_route, 1'b0};
               end
            end
            S_DATA: begin
               if (!is_full && MULTI_FLIT) begin
                  wrreq    = 1'b1;
                  data_out = {cur_flit, 1'b0};
               end
            end
            default: begin
               if (continue_worm) begin
                  PC_in_channel_a = 1'b1;
                  wrreq           = 1'b1;
                  data_out        = {held, 1'b0};
               end else if (close_worm && !is_full) begin
                  wrreq    = 1'b1;
                  data_out = {held, 1'b1};
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) begin
         state      <= S_IDLE;
         payload    <= '0;
         last_route <= '0;
         idx        <= '0;
         held       <= '0;
         timer      <= '0;
         words      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (PC_in_channel_v) begin
                  payload    <= in_payload;
                  last_route <= in_route;
                  words      <= CW'(1);
                  state      <= S_HDR;
               end
            end
            S_HDR: begin
               if (!is_full) begin
                  idx   <= '0;
                  state <= S_DATA;
               end
            end
            S_DATA: begin
               // The last flit is parked, not written, until the worm's fate is known.
               if (!MULTI_FLIT) begin
                  held  <= padded[W-1:0];
                  timer <= '0;
                  state <= S_HOLD;
               end else if (!is_full) begin
                  if (idx == IDX_PENULT) begin
                     held  <= padded[W-1:0];
                     timer <= '0;
                     state <= S_HOLD;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
            end
            default: begin
               if (continue_worm) begin
                  payload <= in_payload;
                  words   <= words + CW'(1);
                  timer   <= '0;
                  idx     <= '0;
                  state   <= S_DATA;
               end else if (close_worm && !is_full) begin
                  state <= S_IDLE;
               end else if (!timed_out) begin
                  timer <= timer + TW'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bz_worm_serializer.sv
// Self-checking bench for bz_worm_serializer: directed and randomized words compared against
// a flit-stream model built from the worm rules (grouping, padding, tail placement, timing).
module tb_bz_worm_serializer;

   localparam int NPCroute  = 10;
   localparam int NPCcode   = 8;
   localparam int NPCdata   = 24;
   localparam int NHold     = 16;
   localparam int NMaxWords = 8;
   localparam int W  = NPCroute;
   localparam int NP = NPCcode + NPCdata;
   localparam int K  = (NP + W - 1) / W;
   localparam int DW = NPCroute + NP;
   localparam int T  = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] d = '0;
   logic          v = 1'b0;
   logic          a;
   logic          is_full = 1'b0;
   logic [W:0]    data_out;
   logic          wrreq;

   int checks = 0;
   int errors = 0;
   int viol = 0;
   int idle_bad = 0;
   bit full_rand = 1'b0;

   logic [W:0]    wq[$];
   time           wt[$];
   time           acc_t[$];
   logic [W:0]    exp_q[$];
   logic [W-1:0]  rs_q[$];
   logic [NP-1:0] ps_q[$];

   always #5 clk = ~clk;

   bz_worm_serializer #(
      .NPCroute(NPCroute), .NPCcode(NPCcode), .NPCdata(NPCdata),
      .NHold(NHold), .NMaxWords(NMaxWords)
   ) dut (
      .clk(clk), .reset(reset),
      .PC_in_channel_d(d), .PC_in_channel_v(v), .PC_in_channel_a(a),
      .is_full(is_full), .data_out(data_out), .wrreq(wrreq)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 2 time units later.
   initial forever begin
      @(negedge clk);
      is_full = full_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
   end

   initial forever begin
      @(negedge clk);
      #2;
      if (wrreq === 1'b1) begin
         wq.push_back(data_out);
         wt.push_back($time);
         if (is_full !== 1'b0) viol++;
      end else if (data_out !== '0) begin
         idle_bad++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [W-1:0] flit_of(input logic [NP-1:0] p, input int i);
      logic [W-1:0] f;
      int pos;
      f = '0;
      for (int b = 0; b < W; b++) begin
         pos = NP - 1 - (i * W + b);
         if (pos >= 0) f[W-1-b] = p[pos];
      end
      return f;
   endfunction

   task automatic add_header(input logic [W-1:0] r);
      exp_q.push_back({r, 1'b0});
   endtask

   task automatic add_word(input logic [NP-1:0] p, input bit last);
      logic t;
      for (int i = 0; i < K; i++) begin
         t = last && (i == K - 1);
         exp_q.push_back({flit_of(p, i), t});
      end
   endtask

   // Words sent back-to-back: a worm breaks on route change or after NMaxWords words.
   task automatic model_stream();
      int cnt;
      bit last;
      cnt = 0;
      for (int i = 0; i < rs_q.size(); i++) begin
         if (i == 0 || rs_q[i] != rs_q[i-1] || cnt == NMaxWords) begin
            add_header(rs_q[i]);
            cnt = 0;
         end
         cnt++;
         last = (i == rs_q.size() - 1) || (cnt == NMaxWords);
         if (!last) last = (rs_q[i+1] != rs_q[i]);
         add_word(ps_q[i], last);
      end
   endtask

   task automatic clear();
      wq.delete(); wt.delete(); acc_t.delete(); exp_q.delete();
      rs_q.delete(); ps_q.delete();
      viol = 0;
      idle_bad = 0;
   endtask

   // Called right after a falling edge; returns right after the falling edge following acceptance.
   task automatic send_word(input logic [W-1:0] r, input logic [NP-1:0] p);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      d = {r, p};
      v = 1'b1;
      while (!done) begin
         #2;
         if (a === 1'b1) begin
            done = 1'b1;
            acc_t.push_back($time);
         end else if (n > 1000) begin
            check("accept_timeout", a, 1);
            done = 1'b1;
         end
         @(negedge clk);
         n++;
      end
      v = 1'b0;
   endtask

   task automatic send_queued();
      for (int i = 0; i < rs_q.size(); i++) send_word(rs_q[i], ps_q[i]);
   endtask

   task automatic compare_stream(input string tag, input int budget);
      int n;
      n = 0;
      while (wq.size() < exp_q.size() && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (NHold + 3 * K + 6) @(negedge clk);
      check($sformatf("%s_count", tag), wq.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
         check($sformatf("%s_flit%0d", tag, i), wq[i], exp_q[i]);
      check($sformatf("%s_full_write", tag), viol, 0);
      check($sformatf("%s_idle_zero", tag), idle_bad, 0);
   endtask

   initial begin
      logic [NP-1:0] p0;
      logic [NP-1:0] p1;
      logic [W-1:0]  r0;
      logic [W-1:0]  r1;
      p0 = {8'hAB, 24'h123456};

      // Reset state, with a word offered during reset that must not be acked.
      repeat (2) @(negedge clk);
      v = 1'b1;
      d = {10'h155, p0};
      #2;
      check("reset_ack", a, 0);
      check("reset_wrreq", wrreq, 0);
      check("reset_data", data_out, 0);
      @(negedge clk);
      v = 1'b0;
      reset = 1'b0;
      #2;
      check("post_reset_wrreq", wrreq, 0);
      check("post_reset_data", data_out, 0);

      // Single word closed by the idle timeout.
      @(negedge clk);
      clear();
      send_word(10'h155, p0);
      add_header(10'h155);
      add_word(p0, 1'b1);
      compare_stream("single", 400);
      if (wt.size() >= 5 && acc_t.size() >= 1) begin
         check("hdr_latency", wt[0] - acc_t[0], T);
         for (int i = 1; i < K; i++)
            check($sformatf("data%0d_latency", i - 1), wt[i] - acc_t[0], (i + 1) * T);
         check("timeout_tail", wt[4] - wt[3], (NHold + 1) * T);
      end

      // Two same-route words in one worm.
      @(negedge clk);
      clear();
      send_word(10'h155, p0);
      send_word(10'h155, p0);
      add_header(10'h155);
      add_word(p0, 1'b0);
      add_word(p0, 1'b1);
      compare_stream("same_route", 400);
      if (wt.size() >= 6 && acc_t.size() >= 2) begin
         check("cont_ack_with_held", acc_t[1], wt[4]);
         check("cont_next_flit", wt[5] - wt[4], T);
      end

      // Route change closes the worm before the next word is acked.
      @(negedge clk);
      clear();
      send_word(10'h155, p0);
      send_word(10'h0F0, p0);
      add_header(10'h155);
      add_word(p0, 1'b1);
      add_header(10'h0F0);
      add_word(p0, 1'b1);
      compare_stream("route_change", 400);
      if (wt.size() >= 5 && acc_t.size() >= 2)
         check("ack_after_tail", acc_t[1] - wt[4], T);

      // Word-count limit: nine same-route random words.
      @(negedge clk);
      clear();
      r0 = W'($urandom);
      for (int i = 0; i < NMaxWords + 1; i++) begin
         rs_q.push_back(r0);
         ps_q.push_back(NP'($urandom));
      end
      send_queued();
      model_stream();
      compare_stream("word_limit", 800);

      // Backpressure across the single-word case.
      @(negedge clk);
      clear();
      full_rand = 1'b1;
      send_word(10'h155, p0);
      add_header(10'h155);
      add_word(p0, 1'b1);
      compare_stream("full_single", 2000);
      if (wt.size() >= 5)
         check("full_tail_not_early", (wt[4] - wt[3]) >= (NHold + 1) * T, 1);

      // Randomized routes and payloads under random backpressure.
      @(negedge clk);
      clear();
      r0 = W'($urandom);
      r1 = r0 + W'(1);
      for (int i = 0; i < 20; i++) begin
         rs_q.push_back(($urandom_range(0, 3) == 0) ? r1 : r0);
         ps_q.push_back(NP'($urandom));
      end
      send_queued();
      model_stream();
      compare_stream("random", 4000);
      full_rand = 1'b0;

      // Reset during DATA of word 1, then word 2.
      @(negedge clk);
      @(negedge clk);
      clear();
      send_word(10'h155, p0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #2;
      check("rst_mid_wrreq", wrreq, 0);
      check("rst_mid_data", data_out, 0);
      #1;
      check("rst_pre_count", wq.size(), 2);
      if (wq.size() >= 2) begin
         check("rst_pre_hdr", wq[0], {10'h155, 1'b0});
         check("rst_pre_flit0", wq[1], {flit_of(p0, 0), 1'b0});
      end
      @(negedge clk);
      clear();
      p1 = NP'($urandom);
      send_word(10'h0F0, p1);
      add_header(10'h0F0);
      add_word(p1, 1'b1);
      compare_stream("after_reset", 400);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bz_worm_serializer.md
# bz_worm_serializer

Parametrised successor to the core-to-router serializer. It accepts `{route, code, data}` words from the core-side Channel and emits 11-bit-style router flits (`{payload, tail}`) into the router input FIFO. It generalises payload and flit widths. It also keeps a worm open across consecutive words to the same route, holding back each word's last flit until it knows whether the worm continues. The worm is closed on route change, on a word-count limit, or when an idle timeout expires.

## Interface
Parameters:
- `NPCroute`, default 10: route field width. Flit width is `NPCroute+1`.
- `NPCcode`, default 8: code field width.
- `NPCdata`, default 24: data field width.
- `NHold`, default 16: idle cycles a worm stays open after its last word. 0 means close immediately.
- `NMaxWords`, default 8: maximum words carried per worm.

Ports:
- `clk`  in  1  clock; one clock domain.
- `reset`  in  1  synchronous, active-high.
- `PC_in_channel`  Channel  `NPCroute+NPCcode+NPCdata`  input words.
  - Fields `d`, `v`, `a`.
  - `d = {route, code, data}`, route in the MSBs.
  - A word transfers in any cycle where `v && a`.
- `is_full`  in  1  full flag of the destination FIFO.
- `data_out`  out  `NPCroute+1`  flit; payload in `[NPCroute:1]`, tail in bit 0.
- `wrreq`  out  1  FIFO write strobe; one flit is written per cycle it is high.

## Operation
- Derived values:
  - Payload `P = {code, data}`, width `NP = NPCcode+NPCdata`.
  - Flit payload width `W = NPCroute`.
  - Flits per word `K = ceil(NP/W)`.
- Data flit `i` (0..K-1) carries `P` MSB-first.
  - The last flit is left-aligned, zero-padded in its LSBs.
  - Defaults: `K=4`. Flits are `P[31:22]`, `P[21:12]`, `P[11:2]`, `{P[1:0], 8'b0}`.
- Header flit is `{route, 1'b0}`. Data flits have tail 0, except the final flit of a worm, which has tail 1.
- State registers: `state`, latched payload, `last_route`, flit index, held flit, hold timer, word counter.
- FSM states:
  - **IDLE**: `a = v`. On transfer, latch the word and `last_route`, set words=1, go to HDR.
  - **HDR**: when `!is_full`, write the header and go to DATA with idx=0.
  - **DATA**:
    - When `!is_full`, write flit idx with tail 0 and increment idx.
    - Flit K-1 is never written here. When idx reaches K-1, or immediately if K==1, store it as the held flit, clear the timer and go to HOLD.
  - **HOLD**: evaluated in this priority order.
    - (a) `v`, route == `last_route`, words < `NMaxWords`, `!is_full`:
      - `a=1`; write held flit with tail 0.
      - Latch the new word, words++, timer=0, go to DATA idx=0 (no header).
    - (b) `v` with a different route, or words == `NMaxWords`:
      - `a=0`.
      - When `!is_full`, write held flit with tail 1 and go to IDLE.
      - The waiting word is accepted in IDLE on a later cycle.
    - (c) timer == `NHold`: when `!is_full`, write held flit with tail 1 and go to IDLE.
    - Otherwise the timer increments, saturating at `NHold`.
- Output rules:
  - `wrreq` and `data_out` are combinational decodes of registered state gated by `is_full`.
  - `wrreq` is never high while `is_full` is high.
  - `data_out` is 0 when `wrreq` is low.
- `a` is combinational from `v`, `state`, route compare, word count and `is_full`. It is never high outside IDLE or case (a).

## Timing
- Reset values: `state`=IDLE, held flit cleared, counters 0, `wrreq`=0, `data_out`=0, `a`=0. Registers clear on the first rising edge with `reset` high.
- Reset mid-worm discards the latched word and held flit; no tail is emitted. The downstream FIFO is reset concurrently.
- Latency from IDLE, word accepted in cycle t, with no backpressure:
  - header at t+1;
  - data flits 0..K-2 at t+2..t+K;
  - held flit no earlier than t+K+1.
- Timeout close: the tail flit is written `NHold+1` cycles after entering HOLD, provided `is_full` is low.
- Same-route continuation: the held flit is written in the acceptance cycle, and the new word's flit 0 follows in the next cycle.
- `is_full` stalls any state in place. The timer keeps counting, but a timeout that expires while full closes only once `is_full` drops.
- `v` rising on the same cycle the timer expires: case (a) or (b) wins over (c).
- With `NHold`=0, every word is its own worm.
- Throughput: 1 flit/cycle, plus one header per worm.

## Test plan
- Single word, route=0x155, code=0xAB, data=0x123456, `is_full`=0.
  - Expect writes 0x2AA, 0x558, 0x246, 0x22A, then 0x401 exactly `NHold+1` cycles after entering HOLD.
- Same word sent twice back-to-back, second word's `v` asserted while in HOLD.
  - Expect 0x2AA, 0x558, 0x246, 0x22A, 0x400, 0x558, 0x246, 0x22A, 0x401.
  - One header only; the second `a` pulse is coincident with the 0x400 write.
- Two words with routes 0x155 then 0x0F0.
  - Expect the first worm to end with 0x401 before the second word is acked.
  - The second worm begins with header 0x1E0.
- Nine same-route words, `NMaxWords`=8.
  - Expect the 8th word's last flit with tail 1, then a fresh header for word 9.
- `is_full` toggled pseudo-randomly across the first scenario.
  - Expect an identical flit sequence and `wrreq` never high with `is_full` high.
  - Timeout tail is delayed until `is_full` is low.
- `reset` asserted during DATA of word 1, then word 2 sent.
  - Expect outputs 0 the cycle after reset, no tail flit, and word 2 starting with its header.
